// File: rtl/magma_iter_core.sv
`default_nettype none
// ============================================================================
// magma_iter_core : iterative GOST 28147-89 / Magma (RFC 8891, param-Z) core
// Revision        : 1.0
// ============================================================================
module magma_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [255:0] key,
    input  logic [63:0]  data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  data_out,
    output logic         busy
);

    generate
        if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
            ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rounds_per_cycle
            $error("magma_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [4:0] C_STEP = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] C_LAST = 5'(32 - ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [4:0]    cnt_q;
    logic [255:0]  key_q;
    logic          mode_q;
    logic [63:0]   block_q;
    logic [63:0]   block_d;
    logic          out_valid_q;
    logic [63:0]   data_out_q;

    // Each row lists Pi_box(0..15) left to right, entry x at bits [(15-x)*4 +: 4].
    function automatic logic [3:0] sbox(input logic [2:0] box, input logic [3:0] x);
        logic [63:0] row;
        case (box)
            3'd0:    row = 64'hC462A5B9E8D703F1;
            3'd1:    row = 64'h68239A5C1E47BD0F;
            3'd2:    row = 64'hB3582FADE174C960;
            3'd3:    row = 64'hC821D4F670A53E9B;
            3'd4:    row = 64'h7F5A816D093EB42C;
            3'd5:    row = 64'h5DF692CAB78143E0;
            3'd6:    row = 64'h8E25691CF4B0DA37;
            default: row = 64'h17ED05834FA69CB2;
        endcase
        return row[{~x, 2'b00} +: 4];
    endfunction

    function automatic logic [31:0] g_func(input logic [31:0] k, input logic [31:0] a);
        logic [31:0] t;
        logic [31:0] s;
        t = a + k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s[4*i +: 4] = sbox(3'(i), t[4*i +: 4]);
        end
        return {s[20:0], s[31:21]};
    endfunction

    // Reverse (K8..K1) order: encrypt only in the last octet, decrypt in all but the first.
    function automatic logic [31:0] round_key(input logic [255:0] k, input logic [4:0] r,
                                              input logic dec);
        logic       rev;
        logic [2:0] idx;
        rev = dec ? (r[4:3] != 2'b00) : (r[4:3] == 2'b11);
        idx = rev ? ~r[2:0] : r[2:0];
        return k[{~idx, 5'b00000} +: 32];
    endfunction

    always_comb begin
        block_d = block_q;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            block_d = {block_d[31:0],
                       g_func(round_key(key_q, cnt_q + 5'(i), mode_q), block_d[31:0])
                       ^ block_d[63:32]};
        end
    end

    // The final round skips the swap, which is simply the swapped halves of block_d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            key_q       <= '0;
            mode_q      <= 1'b0;
            block_q     <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        key_q   <= key;
                        mode_q  <= mode;
                        block_q <= data_in;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    block_q <= block_d;
                    cnt_q   <= cnt_q + C_STEP;
                    if (cnt_q == C_LAST) begin
                        data_out_q  <= {block_d[31:0], block_d[63:32]};
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule
`default_nettype wire

// File: doc/magma_iter_core.md
MAGMA_ITER_CORE -- requirements
Module: magma_iter_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, rounds computed per clock; legal values 1, 2, 4, 8; other values SHALL fail elaboration.
REQ-002 SHALL have one clock and asynchronous active-low reset: clk input 1, rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  input block and key present.
REQ-005 in_ready  output  1  core can accept a block.
REQ-006 mode  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-007 key  input  256  K1 = key[255:224] ... K8 = key[31:0]; sampled on accept.
REQ-008 data_in  input  64  block; a1 = data_in[63:32], a0 = data_in[31:0].
REQ-009 out_valid  output  1  data_out holds a finished result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 data_out  output  64  result block.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 Cipher SHALL be GOST 28147-89 / Magma per RFC 8891: S-box set id-tc26-gost-28147-param-Z, 32 rounds.
REQ-014 Round function SHALL be g(k,a) = rotl11(S((a + k) mod 2^32)); S applies box i to nibble i, nibble 0 = bits [3:0].
REQ-015 Rounds 1-31 SHALL map (a1,a0) -> (a0, g(k,a0) xor a1); round 32 SHALL map (a1,a0) -> (g(k,a0) xor a1, a0) with no swap.
REQ-016 Encrypt key order SHALL be K1..K8 three times, then K8..K1.
REQ-017 Decrypt key order SHALL be K1..K8 once, then K8..K1 three times.
REQ-018 Round key SHALL be selected from a 5-bit round counter and the latched mode; no per-round key storage beyond the latched 256-bit key.
REQ-019 FSM states SHALL be IDLE, RUN, DONE.
REQ-020 IDLE: in_ready = 1. in_valid high at a rising edge SHALL latch data_in, key and mode, clear the counter, and go to RUN.
REQ-021 RUN: in_ready = 0. Each cycle SHALL perform ROUNDS_PER_CYCLE rounds and add ROUNDS_PER_CYCLE to the counter. The final RUN cycle SHALL load data_out, set out_valid and go to DONE.
REQ-022 Latency SHALL be 32/ROUNDS_PER_CYCLE cycles: an accept at edge N gives out_valid = 1 after edge N + 32/ROUNDS_PER_CYCLE.
REQ-023 DONE: out_valid = 1 and data_out SHALL stay stable until out_valid and out_ready are both high at an edge. That edge SHALL go to IDLE and clear out_valid.
REQ-024 in_ready SHALL be low in DONE, with no same-cycle bypass; the next accept is possible one cycle after the output handshake.
REQ-025 in_valid, key, mode and data_in changes during RUN or DONE SHALL be ignored.
REQ-026 out_ready high while out_valid is low SHALL have no effect.
REQ-027 Counter SHALL wrap 31 -> 0 only on the RUN -> DONE transition; it SHALL never produce round 33.
REQ-028 Throughput SHALL be one block per 32/ROUNDS_PER_CYCLE + 2 cycles with out_ready tied high.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, out_valid = 0, data_out = 0, counter = 0, and clear the latched key, mode and block; in_ready = 1 and busy = 0 while in IDLE.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation with no partial result output. The first accept after release SHALL behave as from power-up.
REQ-031 Reset release SHALL be synchronised externally; the core SHALL not accept on the edge coincident with deassertion.

Verification
REQ-032 Encrypt test: key = ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data_in = fedcba9876543210, mode = 0 -> data_out = 4ee901e5c2d8ca3d, out_valid after exactly 32/ROUNDS_PER_CYCLE cycles.
REQ-033 Decrypt test: same key, data_in = 4ee901e5c2d8ca3d, mode = 1 -> data_out = fedcba9876543210.
REQ-034 Backpressure: out_ready held low 10 cycles after completion -> data_out stable, in_ready = 0, a new in_valid is ignored; on out_ready = 1 -> IDLE next cycle.
REQ-035 Reset in the middle of RUN at round 16, then reassert the encrypt test -> out_valid stays 0 until fresh completion, result 4ee901e5c2d8ca3d.
REQ-036 Regression: 1000 random key/block pairs, encrypt then decrypt -> original block, for each ROUNDS_PER_CYCLE in {1, 2, 4, 8}, checked against a software model.
REQ-037 Back-to-back: in_valid and out_ready tied high -> accepts exactly every 32/ROUNDS_PER_CYCLE + 2 cycles, with no lost or duplicated outputs.
